// File: rtl/carry_output_reg.sv
// carry_output_reg -- configurable output stage for one carry-chain slice.
//
// Each of the INPUTS lanes picks its source (carry-chain sum S[i] or LUT
// bypass L[i]) and presents it either combinationally or through a data
// register. Lane behaviour comes from a serially loaded configuration chain.
// Lane i occupies config bits [3i+2:3i] = {init_i, src_i, reg_i}.
//
// Optional feature: define CARRY_OUT_REG_EN to add two config bits
// [3*INPUTS+1:3*INPUTS] = {co_init, co_reg}. These make the carry-out
// registrable as well. Without the macro, co_out is Co passed straight
// through (still gated by ready).
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset
//   S        : carry-chain sum bits, one per lane
//   Co       : carry-chain carry-out
//   L        : LUT outputs bypassing the chain, one per lane
//   ce       : data register clock enable
//   sr       : synchronous load of per-lane init values into data registers
//   cfg_en   : config shift enable
//   cfg_in   : serial config data in (enters the top of the chain)
//   cfg_out  : serial config data out (config bit 0), for daisy-chaining
//   out      : lane outputs, forced to 0 unless ready
//   co_out   : carry-out to the next slice, forced to 0 unless ready
//   ready    : a complete, correctly sized configuration is held
//   cfg_err  : sticky flag for a short or long config load, cleared by reset
module carry_output_reg #(
    parameter int INPUTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] S,
    input  logic              Co,
    input  logic [INPUTS-1:0] L,
    input  logic              ce,
    input  logic              sr,
    input  logic              cfg_en,
    input  logic              cfg_in,
    output logic              cfg_out,
    output logic [INPUTS-1:0] out,
    output logic              co_out,
    output logic              ready,
    output logic              cfg_err
);

`ifdef CARRY_OUT_REG_EN
    localparam int CFG_W = 3*INPUTS + 2;
`else
    localparam int CFG_W = 3*INPUTS;
`endif

    // The counter must be able to hold CFG_W+1 so a long load is recognisable.
    localparam int                CNT_W    = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(CFG_W + 1);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic [INPUTS-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic              err_q, err_d;

    logic [INPUTS-1:0] lane_init, lane_src, lane_reg;
    logic [INPUTS-1:0] src_val, lane_out;

    // Unpack the per-lane fields and build the lane datapath.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            lane_init[i] = cfg_q[3*i+2];
            lane_src[i]  = cfg_q[3*i+1];
            lane_reg[i]  = cfg_q[3*i];
        end
        src_val  = (lane_src & S) | (~lane_src & L);
        lane_out = (lane_reg & data_q) | (~lane_reg & src_val);
    end

    // Next-state logic for config chain, data registers and load FSM.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        cfg_d   = cfg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        err_d   = err_q;

        // A shift freezes the data registers even when sr or ce is also high.
        if (cfg_en) begin
            cfg_d = {cfg_in, cfg_q[CFG_W-1:1]};
        end else if (sr) begin
            data_d = lane_init;
        end else if (ce) begin
            data_d = src_val;
        end

        case (state_q)
            UNCFG, READY: begin
                if (cfg_en) begin
                    state_d = LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOAD: begin
                if (cfg_en) begin
                    // Saturate one past full length: any longer load is simply "too long".
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == CNT_FULL) begin
                    state_d = READY;
                end else begin
                    state_d = UNCFG;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = UNCFG;
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            state_q <= UNCFG;
            err_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign ready   = (state_q == READY);
    assign cfg_err = err_q;
    assign cfg_out = cfg_q[0];
    assign out     = ready ? lane_out : '0;

`ifdef CARRY_OUT_REG_EN
    logic co_q, co_d;
    logic co_reg, co_init;

    assign co_reg  = cfg_q[3*INPUTS];
    assign co_init = cfg_q[3*INPUTS+1];

    // Same cfg_en / sr / ce priority as the lane data registers.
    always_comb begin
        co_d = co_q;
        if (cfg_en) begin
            co_d = co_q;
        end else if (sr) begin
            co_d = co_init;
        end else if (ce) begin
            co_d = Co;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            co_q <= 1'b0;
        end else begin
            co_q <= co_d;
        end
    end

    assign co_out = ready & (co_reg ? co_q : Co);
`else
    assign co_out = ready & Co;
`endif

endmodule

// File: doc/carry_output_reg.md
CARRY_OUTPUT_REG -- requirements
Module: carry_output_reg

Interface
REQ-001 SHALL have parameter INPUTS, default 4, giving the number of lanes, i.e. the carry-chain width.
REQ-002 SHALL have derived constant CFG_W: 3*INPUTS, or 3*INPUTS+2 with CARRY_OUT_REG_EN, giving the config chain length.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port S, input, INPUTS bits: sum bits from the carry chain.
REQ-006 SHALL have port Co, input, 1 bit: carry-out from the carry chain.
REQ-007 SHALL have port L, input, INPUTS bits: LUT outputs bypassing the chain.
REQ-008 SHALL have port ce, input, 1 bit: data register clock enable.
REQ-009 SHALL have port sr, input, 1 bit: synchronous load of per-lane init values into the data registers.
REQ-010 SHALL have port cfg_en, input, 1 bit: config shift enable.
REQ-011 SHALL have port cfg_in, input, 1 bit: serial config data in.
REQ-012 SHALL have port cfg_out, output, 1 bit: serial config data out (config bit 0), for daisy-chaining.
REQ-013 SHALL have port out, output, INPUTS bits: lane outputs.
REQ-014 SHALL have port co_out, output, 1 bit: carry-out to the next slice.
REQ-015 SHALL have port ready, output, 1 bit: high when a complete configuration is held.
REQ-016 SHALL have port cfg_err, output, 1 bit: sticky flag for a short or long config load.

Function
REQ-017 SHALL hold lane i config at bits [3i+2:3i] = {init_i, src_i, reg_i}.
REQ-018 SHALL select the lane source as S[i] when src_i=1 and L[i] when src_i=0.
REQ-019 SHALL drive out[i] from the data register when reg_i=1 (1-cycle latency) and from the source combinationally when reg_i=0 (0 latency).
REQ-020 SHALL apply data register priority per edge: cfg_en (hold), then sr (load init_i), then ce (capture source), else hold.
REQ-021 SHALL, on each edge with cfg_en=1, shift config right by one: cfg_in enters bit CFG_W-1 and bit 0 leaves via cfg_out.
REQ-022 SHALL implement FSM states UNCFG, LOAD, READY; reset state is UNCFG.
REQ-023 SHALL transition UNCFG or READY to LOAD on cfg_en=1, clearing the shift counter to 1 for the first shift.
REQ-024 SHALL, in LOAD with cfg_en=1, increment the counter, saturating at CFG_W+1.
REQ-025 SHALL, in LOAD with cfg_en=0: go to READY if the counter equals CFG_W; otherwise go to UNCFG and set cfg_err.
REQ-026 SHALL clear cfg_err only on reset.
REQ-027 SHALL assert ready only in state READY.
REQ-028 SHALL force out and co_out to 0 whenever ready=0; the config and data registers keep their values.
REQ-029 SHALL leave cfg_out valid in every state.
REQ-030 SHALL, when sr=1 and cfg_en=1 occur together, shift config and leave the data registers unchanged.
REQ-031 SHALL, on reconfiguration from READY, deassert ready on the first cfg_en edge and reassert it only after a full-length load.

Reset
REQ-032 SHALL, on an edge with rst_n=0, clear config, data registers and counter, set the state to UNCFG, and clear cfg_err.
REQ-033 SHALL hold these reset output values: out=0, co_out=0, ready=0, cfg_err=0, cfg_out=0.
REQ-034 SHALL let reset mid-load abort the load, with the partial config discarded.
REQ-035 SHALL give rst_n priority over cfg_en, sr and ce.

Configuration
REQ-036 SHALL, with macro CARRY_OUT_REG_EN defined, add config bits [3*INPUTS+1:3*INPUTS] = {co_init, co_reg}, where co_reg=1 registers Co under the same cfg_en/sr/ce priority (sr loads co_init) and co_reg=0 passes Co combinationally.
REQ-037 SHALL, without CARRY_OUT_REG_EN, drive co_out = Co combinationally (gated by ready), with no extra config bits and CFG_W=3*INPUTS.

Verification
REQ-038 SHALL cover: INPUTS=4, no macro, shift in 12 bits with all lanes reg=1, src=1 -> ready=1; S=4'b1010, ce=1 -> out=4'b1010 one cycle later; ce=0, S=4'b0101 -> out holds 4'b1010.
REQ-039 SHALL cover: lanes reg=0, src=0, L=4'b0110 -> out=4'b0110 in the same cycle; Co=1 -> co_out=1.
REQ-040 SHALL cover: init bits 4'b1001, sr=1 and ce=1 on the same edge -> out=4'b1001, not the source value.
REQ-041 SHALL cover: load 11 bits then cfg_en=0 -> state UNCFG, cfg_err=1, out=0; load 13 bits -> cfg_err=1, ready=0.
REQ-042 SHALL cover: rst_n=0 after 6 shifts -> the next cycle has ready=0, cfg_err=0, cfg_out=0 and the config fully cleared.
REQ-043 SHALL cover: with CARRY_OUT_REG_EN, load 14 bits with co_reg=1, co_init=1, then sr=1 -> co_out=1; then ce=1, Co=0 -> co_out=0 one cycle later.
